// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: pipeline depth calculation and the per-stage
// control bundle carried alongside the data in every pipeline register.
package arith_pkg;

  // Number of SIZE-bit blocks, one block per pipeline stage.
  function automatic int unsigned stages(input int unsigned n, input int unsigned size);
    return n / size;
  endfunction

  // Per-stage control: occupancy plus the carry handed to the next block.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/csel_sub_block.sv
// One carry-select block: adds a block and an inverted-b block for both
// possible carries in parallel, then picks the pair matching carry_i.
// Ports: a_i, b_inv_i (SIZE), carry_i -> sum_o (SIZE), carry_o. Combinational.
module csel_sub_block #(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_inv_i,
  input  logic            carry_i,
  output logic [SIZE-1:0] sum_o,
  output logic            carry_o
);

  logic [SIZE-1:0] sum0;
  logic [SIZE-1:0] sum1;
  logic            cout0;
  logic            cout1;

  ripple_carry_adder #(.W(SIZE)) u_rca_c0 (
    .a_i    (a_i),
    .b_i    (b_inv_i),
    .cin_i  (1'b0),
    .sum_o  (sum0),
    .cout_o (cout0)
  );

  ripple_carry_adder #(.W(SIZE)) u_rca_c1 (
    .a_i    (a_i),
    .b_i    (b_inv_i),
    .cin_i  (1'b1),
    .sum_o  (sum1),
    .cout_o (cout1)
  );

  // Late-arriving carry only drives the final select.
  assign sum_o   = carry_i ? sum1 : sum0;
  assign carry_o = carry_i ? cout1 : cout0;

endmodule

// File: rtl/ripple_carry_adder.sv
// W-bit adder with carry in/out; the building block for each carry-select half.
// Ports: a_i, b_i (W), cin_i -> sum_o (W), cout_o.
module ripple_carry_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = (W+1)'(a_i) + (W+1)'(b_i) + (W+1)'(cin_i);

endmodule

// File: rtl/pipelined_csel_subtractor.sv
// Pipelined N-bit subtractor (diff = a + ~b + 1), one SIZE-bit carry-select
// block per stage, with valid/ready flow control on both sides.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; a, b (N) operands
//   out_valid/out_ready result handshake; diff (N), borrow, ovf results
module pipelined_csel_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned SIZE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int unsigned STAGES = stages(N, SIZE);

  if ((N % SIZE) != 0) begin : g_param_check
    $error("pipelined_csel_subtractor: N must be a multiple of SIZE");
  end

  // Stage registers. Operands are stored pre-shifted so the block a stage
  // consumes is always in the low SIZE bits; diff is built from the top down
  // so it lands in place after the last stage.
  stage_ctl_t   ctl_q    [STAGES];
  stage_ctl_t   ctl_d    [STAGES];
  logic [N-1:0] a_q      [STAGES];
  logic [N-1:0] a_d      [STAGES];
  logic [N-1:0] b_q      [STAGES];
  logic [N-1:0] b_d      [STAGES];
  logic [N-1:0] diff_q   [STAGES];
  logic [N-1:0] diff_d   [STAGES];
  logic         borrow_q;
  logic         borrow_d;
  logic         ovf_q;
  logic         ovf_d;

  // Per-stage inputs and block results.
  logic [N-1:0]    src_a     [STAGES];
  logic [N-1:0]    src_b     [STAGES];
  logic [N-1:0]    src_diff  [STAGES];
  logic            src_cin   [STAGES];
  logic            src_valid [STAGES];
  logic [SIZE-1:0] blk_sum   [STAGES];
  logic            blk_cout  [STAGES];

  logic advance;

  // Whole pipeline moves in lockstep; bubbles shift like data.
  assign advance  = !ctl_q[STAGES-1].valid || out_ready;
  assign in_ready = advance;

  // Stage 0 reads the ports with carry-in 1; later stages read their predecessor.
  always_comb begin
    src_a[0]     = a;
    src_b[0]     = b;
    src_diff[0]  = '0;
    src_cin[0]   = 1'b1;
    src_valid[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      src_a[i]     = a_q[i-1];
      src_b[i]     = b_q[i-1];
      src_diff[i]  = diff_q[i-1];
      src_cin[i]   = ctl_q[i-1].carry;
      src_valid[i] = ctl_q[i-1].valid;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    csel_sub_block #(.SIZE(SIZE)) u_blk (
      .a_i     (src_a[g][SIZE-1:0]),
      .b_inv_i (~src_b[g][SIZE-1:0]),
      .carry_i (src_cin[g]),
      .sum_o   (blk_sum[g]),
      .carry_o (blk_cout[g])
    );
  end

  // Next-state for every stage register plus the final flags.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      ctl_d[i].valid = src_valid[i];
      ctl_d[i].carry = blk_cout[i];
      a_d[i]         = src_a[i] >> SIZE;
      b_d[i]         = src_b[i] >> SIZE;
      diff_d[i]      = (src_diff[i] >> SIZE) | (N'(blk_sum[i]) << (N - SIZE));
    end
    // Final carry-out of a + ~b + 1 is the inverse of the unsigned borrow.
    borrow_d = ~blk_cout[STAGES-1];
    // By the last stage the operand MSBs sit at bit SIZE-1 of the block.
    ovf_d    = (src_a[STAGES-1][SIZE-1] != src_b[STAGES-1][SIZE-1]) &&
               (blk_sum[STAGES-1][SIZE-1] != src_a[STAGES-1][SIZE-1]);
  end

  // Valid bits and the output register are reset; interior data is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        ctl_q[i].valid <= 1'b0;
      end
      diff_q[STAGES-1] <= '0;
      borrow_q         <= 1'b0;
      ovf_q            <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        ctl_q[i]  <= ctl_d[i];
        a_q[i]    <= a_d[i];
        b_q[i]    <= b_d[i];
        diff_q[i] <= diff_d[i];
      end
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = ctl_q[STAGES-1].valid;
  assign diff      = diff_q[STAGES-1];
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_csel_subtractor.md
Name: pipelined_csel_subtractor

Overview:
- Pipelined N-bit subtractor computing diff = a - b, processing one SIZE-bit block per pipeline stage.
- Each stage evaluates its block for both incoming-carry values (carry = 0 and carry = 1) and selects the result using the carry registered from the previous stage.
- Provides unsigned borrow and signed overflow.
- Sits in the arithmetic datapath where a full-width carry-select chain would not close timing; uses a valid/ready handshake for backpressure.

Parameters:
- N, 32, operand and result width; must be a multiple of SIZE (elaboration-time $error otherwise).
- SIZE, 8, block width, one block per stage; STAGES = N/SIZE, which is also the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 0 can accept; a transfer occurs when in_valid && in_ready.
- a  input  N  minuend (unsigned or two's complement).
- b  input  N  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- diff  output  N  a - b modulo 2^N.
- borrow  output  1  1 iff a < b unsigned (the inverse of final carry-out).
- ovf  output  1  signed overflow: a[N-1] != b[N-1] && diff[N-1] != a[N-1].

Behaviour:
- Arithmetic: diff = a + ~b + 1.
  - Stage 0 uses carry-in 1.
  - Stage i computes block i (bits SIZE*i+SIZE-1 : SIZE*i) twice, with carry 0 and carry 1.
  - It then muxes the sum and carry-out by the carry held in stage i-1's register.
- Stage registers: each stage register holds a valid bit, the carry, the diff bits completed so far, and the a/b bits still unprocessed. Stage STAGES-1 drives diff/borrow/ovf directly from its register.
- Latency: a result accepted at edge k appears with out_valid = 1 after edge k+STAGES, provided there is no stall.
- Throughput: one operation per cycle.
- Stall rule: advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 0, every stage register holds its value.
  - When advance = 1, every stage shifts forward. Bubbles (valid = 0) shift like data and are not compacted.
- Output stability: while out_valid && !out_ready, diff/borrow/ovf must not change.
- Reset: all valid bits, out_valid, diff, borrow and ovf are 0; in_ready = 1 in the cycle after reset.
- Reset mid-operation: in-flight operations are discarded and none are reported.
- Simultaneous output pop and input push in the same cycle are both accepted; occupancy is unchanged.
- Wrap-around: 0 - 1 = all ones, with borrow = 1 and ovf = 0. No saturation.
- Operand registers for blocks already consumed may be left unloaded; only the remaining upper bits are carried forward.
- Data registers do not require reset. Outputs nevertheless read 0 after reset because the output register is reset.

Decomposition:
- Shared package arith_pkg:
  - constant function stages(N, SIZE);
  - typedef for stage carry/valid bundle.
- Natural sub-module csel_sub_block (parameter SIZE).
  - Inputs: SIZE-bit a block, SIZE-bit inverted b block, carry_in.
  - Internals: two ripple_carry_adder instances (cin 0/1) plus 2:1 muxes, both existing in the codebase.
  - Outputs: SIZE-bit sum, carry_out.
  - Combinational; instantiated once per stage inside a generate loop.

Test Plan:
All scenarios use N=32, SIZE=8, so latency = 4.
1. Basic subtraction:
   - Stimulus: a=0x0000_0005, b=0x0000_0003, out_ready=1.
   - Response: after 4 cycles, diff=0x0000_0002, borrow=0, ovf=0.
2. Wrap-around:
   - Stimulus: a=0x0000_0000, b=0x0000_0001.
   - Response: diff=0xFFFF_FFFF, borrow=1, ovf=0.
   - Stimulus: a=0x8000_0000, b=0x0000_0001.
   - Response: diff=0x7FFF_FFFF, borrow=0, ovf=1.
3. Cross-block borrow propagation:
   - Stimulus: a=0x0100_0000, b=0x0000_0001.
   - Response: diff=0x00FF_FFFF, borrow=0.
4. Back-to-back streaming:
   - Stimulus: 100 random pairs with in_valid held at 1 and out_ready=1.
   - Response: results appear in order on 100 consecutive cycles starting at cycle 4, each matching the a-b reference model.
5. Backpressure:
   - Stimulus: stream 6 operations while holding out_ready=0 for 5 cycles from the first out_valid.
   - Response: in_ready=0 during the stall, outputs stay frozen, and all 6 results are delivered in order with none lost or duplicated.
6. Reset mid-stream:
   - Stimulus: assert rst for 1 cycle while 3 operations are in flight.
   - Response: out_valid=0, diff=0, borrow=0, ovf=0 next cycle; no stale result ever appears; a new operation a=0x10, b=0x20 afterwards gives diff=0xFFFF_FFF0, borrow=1.
